debounce_sync: RTL

//  Conditions a raw, asynchronous, bouncy input (switch/button) into a clean

---
 rtl/debounce_sync_pkg.sv | 22 ++
 rtl/debounce_sync_if.sv | 19 +
 rtl/debounce_sync_sync_chain.sv | 31 +++
 rtl/debounce_sync.sv | 124 ++++++++++++
 4 files changed

// File: rtl/debounce_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_sync_pkg
//  Description : Shared FSM state encodings and default parameter values for
//                the input debouncer / synchronizer.
//  Revision    : 1.0  initial release
// ============================================================================
package debounce_sync_pkg;

    // Debounce FSM states, fixed encodings
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam int c_default_sync_stages     = 2;
    localparam int c_default_debounce_cycles = 4;

endpackage : debounce_sync_pkg
`default_nettype wire

// File: rtl/debounce_sync_if.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_sync_if
//  Description : Raw input and conditioned outputs of the debouncer.
//                master = the side driving the raw input A,
//                slave  = the debouncer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface debounce_sync_if;
    logic A;
    logic X;
    logic RISE;
    logic FALL;
    logic BUSY;

    modport master (output A, input  X, RISE, FALL, BUSY);
    modport slave  (input  A, output X, RISE, FALL, BUSY);
endinterface : debounce_sync_if
`default_nettype wire

// File: rtl/debounce_sync_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Plain flip-flop shift chain bringing an asynchronous level
//                into the CLK domain. No logic between stages.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic D,
    output logic      Q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw input through the chain; stage 0 takes D
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], D};
        end
    end

    assign Q = r_sync[SYNC_STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_sync
//  Description : Synchronizes a bouncy asynchronous input and accepts a level
//                change only after DEBOUNCE_CYCLES consecutive agreeing
//                synchronized samples. Produces a registered level X plus
//                one-cycle RISE/FALL pulses and a BUSY qualification flag.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = c_default_sync_stages,
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    debounce_sync_if.slave  dbif
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             w_s;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_x,     w_x_nxt;
    logic             r_rise,  w_rise_nxt;
    logic             r_fall,  w_fall_nxt;
    logic             r_busy,  w_busy_nxt;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .CLK (CLK),
        .RST (RST),
        .D   (dbif.A),
        .Q   (w_s)
    );

    // State, counter and all outputs are registered together
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state logic: any disagreeing sample during qualification restarts from zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_x_nxt     = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_x_nxt     = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
                w_x_nxt     = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == WAIT_HI) || (w_state_nxt == WAIT_LO);
    end

    assign dbif.X    = r_x;
    assign dbif.RISE = r_rise;
    assign dbif.FALL = r_fall;
    assign dbif.BUSY = r_busy;

endmodule : debounce_sync
`default_nettype wire
